sram_mem_controller: RTL and testbench

//  Sits under MEM_Stage in place of the on-chip data array: turns 32-bit word loads/stores

---
 rtl/sram_mem_controller_pkg.sv | 20 ++
 rtl/sram_mem_controller.sv | 147 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_pkg.sv
// ---------------------------------------------------------------------------
// sram_mem_controller_pkg
//   Shared definitions for the external-SRAM data memory controller: the FSM
//   state encoding and default parameter values, so the CPU top and the
//   bench agree on them.
// ---------------------------------------------------------------------------
package sram_mem_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DATA_BASE_DEFAULT     = 1024;
    localparam int ACCESS_CYCLES_DEFAULT = 6;

endpackage

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//   Replaces the on-chip data array under the MEM stage. Each 32-bit word
//   load/store becomes two 16-bit SRAM accesses (low half, then high half).
//   ready is held low while an access is in flight so the CPU can freeze.
//
// Parameters
//   ACCESS_CYCLES  cycles from the request cycle to ready high, inclusive (3..15)
//   DATA_BASE      byte address mapped to SRAM word 0
//
// Ports
//   clk        in     system clock, rising edge
//   rst        in     asynchronous reset, active-low
//   wrEn       in     store request (level, held while ready=0)
//   rdEn       in     load request (level, held while ready=0)
//   address    in     [31:0] byte address
//   writeData  in     [31:0] store data
//   readData   out    [31:0] load result, valid when ready=1 after a read
//   ready      out    0 = freeze pipeline, 1 = idle or access complete
//   SRAM_DQ    inout  [15:0] SRAM data bus
//   SRAM_ADDR  out    [17:0] SRAM half-word address
//   SRAM_WE_N  out    SRAM write strobe, active-low
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  tied low
// ---------------------------------------------------------------------------
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
    parameter int DATA_BASE     = DATA_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    // With three cycles there is no room for a separate DONE cycle after HI,
    // so the HI cycle itself completes the access: ready rises in HI and the
    // high read half is bypassed straight from the bus onto readData.
    localparam bit         SHORT     = (ACCESS_CYCLES == 3);
    localparam bit         NO_WAIT   = (ACCESS_CYCLES <= 4);
    localparam logic [3:0] WAIT_LAST = 4'(ACCESS_CYCLES - 4);

    state_t      state;
    logic [3:0]  counter;
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] off;
    logic        req;
    logic        drive_dq;

    assign req = wrEn | rdEn;
    assign off = address - 32'(DATA_BASE);

    // Address bits outside the word index are intentionally ignored.
    wire unused_off = ^{off[31:19], off[1:0]};

    assign ready = ~req | (state == ST_DONE) | (SHORT && (state == ST_HI));

    assign drive_dq = op_wr && ((state == ST_LO) || (state == ST_HI));
    assign SRAM_DQ  = drive_dq ? ((state == ST_HI) ? wdata[31:16] : wdata[15:0])
                               : 16'hzzzz;

    assign readData = (SHORT && (state == ST_HI) && !op_wr) ? {SRAM_DQ, rdata[15:0]}
                                                           : rdata;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // Request capture: word index and store data, taken in the IDLE cycle.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && req) begin
            idx   <= off[18:2];
            wdata <= writeData;
        end
    end

    // Access sequencer: IDLE -> LO -> HI -> [WAIT] -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            counter   <= 4'd0;
            rdata     <= 32'd0;
            op_wr     <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_ADDR <= 18'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_LO;
                        op_wr     <= wrEn;  // store wins when both are high
                        SRAM_ADDR <= {off[18:2], 1'b0};
                        SRAM_WE_N <= ~wrEn;
                    end
                end
                ST_LO: begin
                    if (!op_wr) rdata[15:0] <= SRAM_DQ;
                    SRAM_ADDR <= {idx, 1'b1};
                    state     <= ST_HI;
                end
                ST_HI: begin
                    if (!op_wr) rdata[31:16] <= SRAM_DQ;
                    SRAM_WE_N <= 1'b1;
                    if (SHORT) begin
                        state <= ST_IDLE;
                    end else if (NO_WAIT) begin
                        state <= ST_DONE;
                    end else begin
                        state   <= ST_WAIT;
                        counter <= 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (counter == WAIT_LAST) begin
                        state   <= ST_DONE;
                        counter <= 4'd0;
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
//   Directed bench for sram_mem_controller. Two instances share clock and
//   reset: dut6 (ACCESS_CYCLES=6) and dut3 (ACCESS_CYCLES=3), each on its own
//   behavioural 16-bit x 256K SRAM model.
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;
    import sram_mem_controller_pkg::*;

    logic clk;
    logic rst_n;

    logic        wr6, rd6;
    logic [31:0] addr6, wd6;
    wire  [31:0] rdd6;
    wire         rdy6;
    wire  [15:0] dq6;
    wire  [17:0] sa6;
    wire         we6, ub6, lb6, ce6, oe6;

    logic        wr3, rd3;
    logic [31:0] addr3, wd3;
    wire  [31:0] rdd3;
    wire         rdy3;
    wire  [15:0] dq3;
    wire  [17:0] sa3;
    wire         we3, ub3, lb3, ce3, oe3;

    int checks;
    int errors;

    sram_mem_controller #(.ACCESS_CYCLES(6), .DATA_BASE(1024)) dut6 (
        .clk(clk), .rst(rst_n), .wrEn(wr6), .rdEn(rd6), .address(addr6),
        .writeData(wd6), .readData(rdd6), .ready(rdy6), .SRAM_DQ(dq6),
        .SRAM_ADDR(sa6), .SRAM_WE_N(we6), .SRAM_UB_N(ub6), .SRAM_LB_N(lb6),
        .SRAM_CE_N(ce6), .SRAM_OE_N(oe6)
    );

    sram_mem_controller #(.ACCESS_CYCLES(3), .DATA_BASE(1024)) dut3 (
        .clk(clk), .rst(rst_n), .wrEn(wr3), .rdEn(rd3), .address(addr3),
        .writeData(wd3), .readData(rdd3), .ready(rdy3), .SRAM_DQ(dq3),
        .SRAM_ADDR(sa3), .SRAM_WE_N(we3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3),
        .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
    );

    // sram_model: asynchronous read while WE_N is high, write on the clock
    // edge while WE_N is low.
    logic [15:0] mem6 [0:262143];
    logic [15:0] mem3 [0:262143];

    assign dq6 = we6 ? mem6[sa6] : 16'hzzzz;
    assign dq3 = we3 ? mem3[sa3] : 16'hzzzz;

    always @(posedge clk) if (!we6) mem6[sa6] <= dq6;
    always @(posedge clk) if (!we3) mem3[sa3] <= dq3;

    bit wait_seen3 = 1'b0;
    always @(posedge clk) if (dut3.state == ST_WAIT) wait_seen3 <= 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    // Starts an access at posedge+1 and returns the cycle (1 = request cycle)
    // in which ready was first seen high; 0 if it never came.
    task automatic start_access(input bit sel, input bit wr, input bit rd,
                                input logic [31:0] addr, input logic [31:0] data,
                                output int done_cyc);
        if (sel) begin
            wr3 = wr; rd3 = rd; addr3 = addr; wd3 = data;
        end else begin
            wr6 = wr; rd6 = rd; addr6 = addr; wd6 = data;
        end
        done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if ((sel ? rdy3 : rdy6) === 1'b1) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_access(input bit sel);
        @(posedge clk);
        #1;
        if (sel) begin
            wr3 = 1'b0; rd3 = 1'b0;
        end else begin
            wr6 = 1'b0; rd6 = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rdy6, we6, sa6, rdd6} !== {1'b1, 1'b1, 18'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b we_n=%b addr=%h rd=%h, want 1 1 0 0",
                     rdy6, we6, sa6, rdd6);
        end
        checks++;
        if ({ub6, lb6, ce6, oe6} !== 4'b0000) begin
            errors++;
            $display("FAIL tie_offs: got %b want 0000", {ub6, lb6, ce6, oe6});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Abort a store in its HI cycle.
        wr6 = 1'b1; addr6 = 32'd1024; wd6 = 32'h7777_3333;
        @(posedge clk);
        @(posedge clk);
        #3;
        checks++;
        if (we6 !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre_we: got %b want 0", we6);
        end
        rst_n = 1'b0;
        wr6 = 1'b0;
        #1;
        checks++;
        if ({we6, sa6, rdy6, rdd6} !== {1'b1, 18'd0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL abort_state: got we_n=%b addr=%h rdy=%b rd=%h, want 1 0 1 0",
                     we6, sa6, rdy6, rdd6);
        end
        checks++;
        if (dq6 !== 16'h3333) begin
            errors++;
            $display("FAIL abort_bus_released: got %h want 3333", dq6);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        int cyc;
        start_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, cyc);
        checks++;
        if (cyc != 6) begin
            errors++;
            $display("FAIL store_ready_cycle: got %0d want 6", cyc);
        end
        end_access(1'b0);
        checks++;
        if ({mem6[1], mem6[0]} !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_mem: got %h_%h want DEAD_BEEF", mem6[1], mem6[0]);
        end
    endtask

    task automatic test_load();
        int cyc;
        start_access(1'b0, 1'b0, 1'b1, 32'd1024, 32'd0, cyc);
        checks++;
        if (cyc != 6 || rdd6 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_1024: got cyc=%0d data=%h want 6 DEADBEEF", cyc, rdd6);
        end
        end_access(1'b0);
        start_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h1234_5678, cyc);
        end_access(1'b0);
        checks++;
        if ({mem6[3], mem6[2], rdd6} !== {32'h1234_5678, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_1028: got mem=%h_%h rd=%h want 1234_5678 DEADBEEF",
                     mem6[3], mem6[2], rdd6);
        end
        // Low address bits are ignored: 1031 reads the same word as 1028.
        start_access(1'b0, 1'b0, 1'b1, 32'd1031, 32'd0, cyc);
        checks++;
        if (cyc != 6 || rdd6 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL load_1031: got cyc=%0d data=%h want 6 12345678", cyc, rdd6);
        end
        end_access(1'b0);
    endtask

    task automatic test_both_enables();
        int cyc;
        start_access(1'b0, 1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, cyc);
        end_access(1'b0);
        checks++;
        if ({mem6[5], mem6[4], rdd6} !== {32'hA5A5_0F0F, 32'h1234_5678}) begin
            errors++;
            $display("FAIL both_enables: got mem=%h_%h rd=%h want A5A5_0F0F 12345678",
                     mem6[5], mem6[4], rdd6);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        // 0 - 1024 wraps to 0xFFFFFC00 -> word index 0x1FF00 -> SRAM 0x3FE00.
        start_access(1'b0, 1'b1, 1'b0, 32'd0, 32'h0BAD_F00D, cyc);
        end_access(1'b0);
        checks++;
        if ({mem6[18'h3FE01], mem6[18'h3FE00]} !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wrap_store: got %h_%h want 0BAD_F00D",
                     mem6[18'h3FE01], mem6[18'h3FE00]);
        end
        start_access(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, cyc);
        checks++;
        if (rdd6 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wrap_load: got %h want 0BADF00D", rdd6);
        end
        end_access(1'b0);
    endtask

    task automatic test_drop();
        int cyc;
        wr6 = 1'b1; addr6 = 32'd1040; wd6 = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        wr6 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({mem6[9], mem6[8], rdy6} !== {32'h0000_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL drop_store: got mem=%h_%h rdy=%b want 0000_FFFF 1",
                     mem6[9], mem6[8], rdy6);
        end
        start_access(1'b0, 1'b0, 1'b1, 32'd1040, 32'd0, cyc);
        checks++;
        if (cyc != 6 || rdd6 !== 32'h0000_FFFF) begin
            errors++;
            $display("FAIL drop_then_load: got cyc=%0d data=%h want 6 0000FFFF", cyc, rdd6);
        end
        end_access(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [11:0] mask;
        mask = 12'd0;
        rd6 = 1'b1; addr6 = 32'd1024;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            mask[c-1] = rdy6;
            if (c == 6) begin
                checks++;
                if (rdd6 !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL b2b_first: got %h want DEADBEEF", rdd6);
                end
            end
            if (c == 12) begin
                checks++;
                if (rdd6 !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL b2b_second: got %h want 12345678", rdd6);
                end
            end
            @(posedge clk);
            #1;
            if (c == 6) addr6 = 32'd1028;
        end
        rd6 = 1'b0;
        checks++;
        if (mask !== 12'h820) begin
            errors++;
            $display("FAIL b2b_ready_pulses: got %b want 100000100000", mask);
        end
    endtask

    task automatic test_short();
        int cyc;
        start_access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h55AA_33CC, cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL short_store_cycle: got %0d want 3", cyc);
        end
        end_access(1'b1);
        checks++;
        if ({mem3[1], mem3[0]} !== 32'h55AA_33CC) begin
            errors++;
            $display("FAIL short_store_mem: got %h_%h want 55AA_33CC", mem3[1], mem3[0]);
        end
        start_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'd0, cyc);
        checks++;
        if (cyc != 3 || rdd3 !== 32'h55AA_33CC) begin
            errors++;
            $display("FAIL short_load: got cyc=%0d data=%h want 3 55AA33CC", cyc, rdd3);
        end
        end_access(1'b1);
        checks++;
        if (rdd3 !== 32'h55AA_33CC || wait_seen3 !== 1'b0) begin
            errors++;
            $display("FAIL short_hold_nowait: got data=%h wait_seen=%b want 55AA33CC 0",
                     rdd3, wait_seen3);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        wr6 = 1'b0; rd6 = 1'b0; addr6 = 32'd0; wd6 = 32'd0;
        wr3 = 1'b0; rd3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0;

        test_reset();
        test_store();
        test_load();
        test_both_enables();
        test_wrap();
        test_drop();
        test_back_to_back();
        test_short();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
